// File: rtl/tug_of_war_arena.sv
// Tug-of-war game core: synchronised human button on the right, LFSR-driven machine on the left,
// one-hot light position and match scoring with a game-over hold.
module tug_of_war_arena #(
  parameter int unsigned FIELD       = 9,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned LFSR_W      = 10,
  parameter int unsigned MACHINE_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [LFSR_W-1:0] difficulty,
  input  logic              new_game,
  output logic [FIELD-1:0]  field,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic              game_over,
  output logic              winner_l,
  output logic [LFSR_W-1:0] lfsr_out
);

  localparam int unsigned      C      = (FIELD - 1) / 2;
  localparam logic [FIELD-1:0] CENTRE = FIELD'(1) << C;
  localparam logic [3:0]       WIN    = 4'(WIN_SCORE);

  // Tap positions (1-based in the polynomial) mapped onto register bits.
  function automatic logic [31:0] tap_bits(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      default: return 32'h0000_0240;
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_bits(LFSR_W));

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [FIELD-1:0]  field_nx;
  logic [3:0]        score_l_nx, score_r_nx;
  logic              winner_nx;
  logic [LFSR_W-1:0] lfsr;
  logic              s1, s2, prev, armed;
  logic [1:0]        vld;
  logic              strobe_c, carry_c, l_c, r_c;

  // Machine randomness source; seeded at 1 so it can never lock up at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_W'(1);
    else        lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
  end

  assign lfsr_out = lfsr;

  if (MACHINE_DIV == 0) begin : g_nodiv
    assign strobe_c = 1'b1;
  end else begin : g_div
    logic [MACHINE_DIV-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= '0;
      else        cnt <= cnt + MACHINE_DIV'(1);
    end
    assign strobe_c = &cnt;
  end

  // Carry out of lfsr + difficulty, expressed as a compare to avoid a wide adder.
  assign carry_c = (lfsr > ~difficulty);
  assign l_c     = strobe_c & carry_c;

  // Button synchroniser with edge detect; 'armed' blocks a key already held at reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      prev  <= s2;
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & s2);
    end
  end

  assign r_c = prev & ~s2 & armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_PLAY;
      field    <= CENTRE;
      score_l  <= 4'd0;
      score_r  <= 4'd0;
      winner_l <= 1'b0;
    end else begin
      state    <= state_nx;
      field    <= field_nx;
      score_l  <= score_l_nx;
      score_r  <= score_r_nx;
      winner_l <= winner_nx;
    end
  end

  // Move / score / match-end decision; new_game overrides everything.
  always_comb begin
    state_nx   = state;
    field_nx   = field;
    score_l_nx = score_l;
    score_r_nx = score_r;
    winner_nx  = winner_l;
    if (new_game) begin
      state_nx   = ST_PLAY;
      field_nx   = CENTRE;
      score_l_nx = 4'd0;
      score_r_nx = 4'd0;
      winner_nx  = 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (l_c && !r_c) begin
            if (field[FIELD-1]) begin
              score_l_nx = score_l + 4'd1;
              field_nx   = CENTRE;
              if (score_l_nx == WIN) begin
                state_nx  = ST_OVER;
                winner_nx = 1'b1;
              end
            end else begin
              field_nx = field << 1;
            end
          end else if (r_c && !l_c) begin
            if (field[0]) begin
              score_r_nx = score_r + 4'd1;
              field_nx   = CENTRE;
              if (score_r_nx == WIN) begin
                state_nx  = ST_OVER;
                winner_nx = 1'b0;
              end
            end else begin
              field_nx = field >> 1;
            end
          end
        end
        ST_OVER: ;
        default: ;
      endcase
    end
  end

  assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_tug_of_war_arena.sv
// Directed bench for tug_of_war_arena: expected outputs queued per edge and checked after each edge.
module tb_tug_of_war_arena;

  localparam int unsigned FIELD = 9;
  localparam int unsigned WIN   = 3;
  localparam int unsigned LW    = 10;
  localparam int unsigned DIV   = 2;
  localparam logic [8:0]  CENTRE = 9'h010;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_n;
  logic [LW-1:0] difficulty;
  logic          new_game;
  logic [8:0]    field;
  logic [3:0]    score_l, score_r;
  logic          game_over, winner_l;
  logic [LW-1:0] lfsr_out;

  tug_of_war_arena #(
    .FIELD(FIELD), .WIN_SCORE(WIN), .LFSR_W(LW), .MACHINE_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .difficulty(difficulty),
    .new_game(new_game), .field(field), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner_l(winner_l), .lfsr_out(lfsr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] field;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
    logic       wl;
  } exp_t;

  exp_t        sb[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned edges = 0;
  logic [9:0]  lfsr_m;
  logic [8:0]  f_e;
  logic [3:0]  sl_e, sr_e;
  logic        go_e, wl_e;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    lfsr_m = {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    #1;
  endtask

  task automatic model_reset();
    f_e = CENTRE; sl_e = 4'd0; sr_e = 4'd0; go_e = 1'b0; wl_e = 1'b0;
    lfsr_m = 10'd1;
    edges = 0;
  endtask

  task automatic apply_l();
    if (f_e[8]) begin
      sl_e = sl_e + 4'd1;
      f_e  = CENTRE;
      if (sl_e == 4'(WIN)) begin go_e = 1'b1; wl_e = 1'b1; end
    end else f_e = f_e << 1;
  endtask

  task automatic apply_r();
    if (f_e[0]) begin
      sr_e = sr_e + 4'd1;
      f_e  = CENTRE;
      if (sr_e == 4'(WIN)) begin go_e = 1'b1; wl_e = 1'b0; end
    end else f_e = f_e >> 1;
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      cmp({t, "_field"},   32'(field),     32'(e.field));
      cmp({t, "_score_l"}, 32'(score_l),   32'(e.sl));
      cmp({t, "_score_r"}, 32'(score_r),   32'(e.sr));
      cmp({t, "_over"},    32'(game_over), 32'(e.go));
      cmp({t, "_winner"},  32'(winner_l),  32'(e.wl));
      cmp({t, "_lfsr"},    32'(lfsr_out),  32'(lfsr_m));
    end
  endtask

  // One clock edge: r says whether a synchronised press lands on this edge.
  task automatic step(input string tag, input bit r, input bit ng);
    bit   l;
    exp_t e;
    l = (difficulty == 10'h3FF) && ((edges % 4) == 3);
    if (ng) begin
      f_e = CENTRE; sl_e = 4'd0; sr_e = 4'd0; go_e = 1'b0; wl_e = 1'b0;
    end else if (!go_e) begin
      if (l && !r)      apply_l();
      else if (r && !l) apply_r();
    end
    e.field = f_e; e.sl = sl_e; e.sr = sr_e; e.go = go_e; e.wl = wl_e;
    sb.push_back(e);
    tag_q.push_back(tag);
    tick();
    check_out();
  endtask

  task automatic human_press(input string tag);
    key_n = 1'b0;
    step({tag, "_a"}, 1'b0, 1'b0);
    step({tag, "_b"}, 1'b0, 1'b0);
    step({tag, "_c"}, 1'b1, 1'b0);
    step({tag, "_hold"}, 1'b0, 1'b0);
    step({tag, "_hold"}, 1'b0, 1'b0);
    key_n = 1'b1;
    repeat (4) step({tag, "_rel"}, 1'b0, 1'b0);
  endtask

  // Advance until one machine strobe edge has been taken.
  task automatic to_strobe(input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      hit = ((edges % 4) == 3);
      step(tag, 1'b0, 1'b0);
    end
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, "_field"},   32'(field),     32'(CENTRE));
    cmp({tag, "_score_l"}, 32'(score_l),   32'd0);
    cmp({tag, "_score_r"}, 32'(score_r),   32'd0);
    cmp({tag, "_over"},    32'(game_over), 32'd0);
    cmp({tag, "_winner"},  32'(winner_l),  32'd0);
    cmp({tag, "_lfsr"},    32'(lfsr_out),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; key_n = 1'b1; difficulty = '0; new_game = 1'b0;
    model_reset();
    #12;
    check_reset("por");
    reset = 1'b1;

    // Single human press: one step right after the third edge, none while held.
    repeat (5) step("idle", 1'b0, 1'b0);
    human_press("p1");
    cmp("p1_index3", 32'(field), 32'h008);

    // Walk to the right edge, then score.
    human_press("p2");
    human_press("p3");
    human_press("p4");
    cmp("p4_index0", 32'(field), 32'h001);
    human_press("p5");
    cmp("p5_score_r", 32'(score_r), 32'd1);
    cmp("p5_centre",  32'(field),   32'(CENTRE));

    // Machine at full strength wins the match unopposed.
    difficulty = 10'h3FF;
    repeat (4) to_strobe("mach");
    cmp("mach_left_edge", 32'(field), 32'h100);
    to_strobe("mach");
    cmp("mach_point1", 32'(score_l), 32'd1);
    cmp("mach_recentre", 32'(field), 32'(CENTRE));
    repeat (10) to_strobe("mach");
    cmp("mach_won_score", 32'(score_l),   32'd3);
    cmp("mach_won_over",  32'(game_over), 32'd1);
    cmp("mach_won_winl",  32'(winner_l),  32'd1);
    repeat (3) to_strobe("frozen");
    cmp("frozen_score", 32'(score_l), 32'd3);

    // New game clears scores without reseeding the LFSR.
    difficulty = '0;
    new_game = 1'b1;
    step("newgame", 1'b0, 1'b1);
    new_game = 1'b0;
    cmp("newgame_over", 32'(game_over), 32'd0);
    cmp("newgame_score_r", 32'(score_r), 32'd0);
    repeat (2) step("post_ng", 1'b0, 1'b0);

    // Press landing on the same edge as a machine strobe cancels out.
    for (int i = 0; i < 8 && (edges % 4) != 1; i++) step("align", 1'b0, 1'b0);
    difficulty = 10'h3FF;
    key_n = 1'b0;
    step("tie_a", 1'b0, 1'b0);
    step("tie_b", 1'b0, 1'b0);
    step("tie_c", 1'b1, 1'b0);
    cmp("tie_nomove", 32'(field), 32'(CENTRE));
    to_strobe("tie_next");
    cmp("tie_next_left", 32'(field), 32'h020);
    key_n = 1'b1;
    difficulty = '0;
    repeat (4) step("tie_rel", 1'b0, 1'b0);

    // Asynchronous reset mid-game with the key held through release.
    #2;
    reset = 1'b0;
    key_n = 1'b0;
    #1;
    check_reset("async");
    reset = 1'b1;
    model_reset();
    repeat (6) step("held", 1'b0, 1'b0);
    cmp("held_nomove", 32'(field), 32'(CENTRE));
    key_n = 1'b1;
    repeat (4) step("held_rel", 1'b0, 1'b0);
    key_n = 1'b0;
    step("repress_a", 1'b0, 1'b0);
    step("repress_b", 1'b0, 1'b0);
    step("repress_c", 1'b1, 1'b0);
    cmp("repress_moved", 32'(field), 32'h008);
    key_n = 1'b1;
    repeat (3) step("end", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tug_of_war_arena.md
Name: tug_of_war_arena

Overview:
Parametrised tug-of-war game core with a human player on the right, a built-in LFSR machine player on the left, and match scoring. It replaces the fixed 9-LED single-round game plus its external LFSR, adder and button helpers with one block. The playfield width, target score, LFSR width and machine press rate are all configurable. The block sits under the board top level, driving LEDR (field) and the HEX decoders (scores).

Parameters:
FIELD, 9, playfield LEDs; odd, 3..31; centre index C = (FIELD-1)/2
WIN_SCORE, 7, points needed to win the match; 1..15
LFSR_W, 10, machine LFSR / difficulty width; legal 8..12
MACHINE_DIV, 4, machine attempts once every 2^MACHINE_DIV cycles; 0..24

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_n  in  1  raw human pushbutton, active-low, asynchronous to clk
difficulty  in  LFSR_W  machine strength; larger value means more frequent presses
new_game  in  1  synchronous pulse: clear scores, recentre, leave game over
field  out  FIELD  one-hot light position; index FIELD-1 is leftmost
score_l  out  4  machine (left) points
score_r  out  4  human (right) points
game_over  out  1  match finished; field and scores frozen
winner_l  out  1  valid while game_over; 1 = machine won, 0 = human won
lfsr_out  out  LFSR_W  current LFSR state (debug/visibility)

Behaviour:
- Reset (reset=0, async): field one-hot at C; scores 0; game_over 0; winner_l 0; LFSR = 1; strobe counter 0; button sync flops and prev = 1 (released).
- Human press: key_n goes through a 2-flop synchronizer (s1, s2), then prev = registered s2. R = prev & ~s2, one cycle per press, no repeat while held. Effect is visible after the 3rd rising edge following the first edge that samples key_n low.
- LFSR: Fibonacci shift-left every cycle, feedback = XNOR-free XOR of taps. Taps: 8:{8,6,5,4}; 9:{9,5}; 10:{10,7}; 11:{11,9}; 12:{12,6,4,1}. The register never reaches 0.
- Machine: a MACHINE_DIV-bit counter increments every cycle; strobe = counter all ones (every cycle when MACHINE_DIV=0). L = strobe & carry-out of the (LFSR_W+1)-bit sum lfsr + difficulty.
  - difficulty=0 gives L never.
  - difficulty = 2^LFSR_W - 1 gives L on every strobe.
- Move rules, per edge, only when game_over=0:
  - L & R together: no move.
  - L only: position +1, unless at FIELD-1, in which case the machine scores.
  - R only: position -1, unless at 0, in which case the human scores.
- Point scored: that score increments and field returns to C on the same edge.
  - If the new score equals WIN_SCORE: game_over=1 and winner_l set on that edge; field is at C.
- game_over=1: L and R are ignored; field, scores and winner_l hold. LFSR and counter keep running.
- new_game=1: on that edge scores=0, field=C, game_over=0, winner_l=0. It overrides any move or point in the same cycle. LFSR and counter are not reset.
- Scores never exceed WIN_SCORE. All outputs are registered.
- Reset mid-press or mid-game returns to the reset state immediately. A key held through reset release produces no press until it is released and pressed again.

Test Plan:
1. FIELD=9, difficulty=0, one human press (key_n low 5 cycles) -> field moves from index 4 to index 3 exactly 3 edges after key_n is first sampled low; a single step only.
2. difficulty=0, 5 separated presses -> field index 0 after the 4th press; 5th press -> score_r=1, field=index 4.
3. WIN_SCORE=3, difficulty=1023, MACHINE_DIV=2, no key -> L every 4 cycles. Machine scores after 5 strobes per point. After 15 strobes: score_l=3, game_over=1, winner_l=1. Further strobes change nothing.
4. difficulty=1023, MACHINE_DIV=0, key press timed to land with L -> no move that cycle; the next L moves the light left.
5. While game_over=1, pulse new_game -> next edge: scores 0, field=index 4, game_over=0; lfsr_out continues its sequence without reseeding.
6. Assert reset for 1 ns mid-game (async, no clk edge) -> all outputs at reset values immediately; lfsr_out=1. With key_n held low across release, there is no move until release and re-press.
